// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : pipe_ctrl_pkg
// Description : Shared constants for the 5-stage core pipeline control path:
//               pipe-register control codes, hazard sequencer state encoding,
//               instruction-register field offsets and a small helper.
// Revision    : 1.0  initial release
// ============================================================================
package pipe_ctrl_pkg;

    // Pipe-register control codes (2'b11 is reserved and never driven)
    localparam logic [1:0] PM_NORMAL = 2'b00;
    localparam logic [1:0] PM_FLUSH  = 2'b01;
    localparam logic [1:0] PM_FREEZE = 2'b10;

    // Hazard sequencer state encoding
    localparam int         ST_W       = 2;
    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_LSTALL  = 2'd1;
    localparam logic [1:0] ST_FLUSH   = 2'd2;
    localparam logic [1:0] ST_MC_WAIT = 2'd3;

    // Instruction-register field offsets (register index fields)
    localparam int IR_RD_LSB  = 7;
    localparam int IR_RS1_LSB = 15;
    localparam int IR_RS2_LSB = 20;
    localparam int IR_REG_W   = 5;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones instead of wrapping.
// Ports       : clk      - clock, rising edge
//               i_clr_n  - asynchronous active-low clear
//               i_inc    - increment request for this cycle
//               o_count  - current count
// Revision    : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             i_clr_n,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Central stall/flush sequencer for the 5-stage core. Resolves
//               load-use hazards, taken branches resolved in EX and multicycle
//               EX ops, driving IF/ID and ID/EX control codes and PC enable.
// Ports       : clk, reset_n (async active-low)
//               id_rs1/id_rs2/id_use_rs1/id_use_rs2 - ID operand usage
//               ex_mem_read/ex_rd                   - EX load destination
//               branch_taken, mc_start, mc_done     - EX events
//               mux_if_pm/mux_id_ex/pc_write_en     - pipeline controls
//               mc_timeout                          - sticky timeout status
//               stall_cnt/flush_cnt                 - saturating perf counters
// Revision    : 1.0  initial release
// ============================================================================
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW         = 4,
    parameter int LOAD_STALL_CYC = 1,
    parameter int FLUSH_CYC      = 1,
    parameter int MC_TIMEOUT     = 64,
    parameter int PERF_W         = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              branch_taken,
    input  logic              mc_start,
    input  logic              mc_done,
    output logic [1:0]        mux_if_pm,
    output logic [1:0]        mux_id_ex,
    output logic              pc_write_en,
    output logic              mc_timeout,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt
);

    // Shared cycle counter must hold up to (largest length - 1)
    localparam int c_cnt_max = max3(LOAD_STALL_CYC, FLUSH_CYC, MC_TIMEOUT);
    localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;

    localparam logic [c_cnt_w-1:0] c_flush_reload  = c_cnt_w'(FLUSH_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_lstall_reload = c_cnt_w'(LOAD_STALL_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_mc_last       = c_cnt_w'(MC_TIMEOUT - 1);
    localparam bit                 c_flush_multi   = (FLUSH_CYC > 1);
    localparam bit                 c_lstall_multi  = (LOAD_STALL_CYC > 1);

    logic [ST_W-1:0]    r_state;
    logic [ST_W-1:0]    w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               r_mc_timeout;
    logic               w_timeout_set;
    logic               w_flush_inc;
    logic               w_load_use;
    logic               w_mc_release;
    logic [1:0]         w_if_pm;
    logic [1:0]         w_id_ex;
    logic               w_pc_we;
    logic               w_stall_inc;

    assign w_load_use = ex_mem_read && (ex_rd != '0) &&
                        ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                         (id_use_rs2 && (id_rs2 == ex_rd)));

    // MC_WAIT ends on done, or on the last allowed cycle (forced release)
    assign w_mc_release = mc_done || (r_cnt == c_mc_last);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_RUN;
            r_cnt        <= '0;
            r_mc_timeout <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_timeout_set) begin
                r_mc_timeout <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_timeout_set = 1'b0;
        w_flush_inc   = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (branch_taken) begin
                    w_flush_inc = 1'b1;
                    if (c_flush_multi) begin
                        w_state_nxt = ST_FLUSH;
                        w_cnt_nxt   = c_flush_reload;
                    end
                end else if (mc_start) begin
                    w_state_nxt = ST_MC_WAIT;
                    w_cnt_nxt   = '0;
                end else if (w_load_use && c_lstall_multi) begin
                    w_state_nxt = ST_LSTALL;
                    w_cnt_nxt   = c_lstall_reload;
                end
            end
            ST_LSTALL: begin
                // A taken branch aborts the load stall and takes the branch path
                if (branch_taken) begin
                    w_flush_inc = 1'b1;
                    if (c_flush_multi) begin
                        w_state_nxt = ST_FLUSH;
                        w_cnt_nxt   = c_flush_reload;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end else if (r_cnt <= c_cnt_w'(1)) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_FLUSH: begin
                if (branch_taken) begin
                    w_flush_inc = 1'b1;
                    w_cnt_nxt   = c_flush_reload;
                end else if (r_cnt <= c_cnt_w'(1)) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_MC_WAIT: begin
                // mc_start/branch_taken are stale while EX is held
                if (mc_done) begin
                    w_state_nxt = ST_RUN;
                end else if (r_cnt == c_mc_last) begin
                    w_state_nxt   = ST_RUN;
                    w_timeout_set = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic (combinational so the hazard is handled the cycle it shows)
    // ------------------------------------------------------------------
    always_comb begin
        w_if_pm = PM_NORMAL;
        w_id_ex = PM_NORMAL;
        w_pc_we = 1'b1;
        case (r_state)
            ST_RUN: begin
                if (branch_taken) begin
                    w_if_pm = PM_FLUSH;
                    w_id_ex = PM_FLUSH;
                end else if (mc_start) begin
                    w_if_pm = PM_FREEZE;
                    w_id_ex = PM_FREEZE;
                    w_pc_we = 1'b0;
                end else if (w_load_use) begin
                    w_if_pm = PM_FREEZE;
                    w_id_ex = PM_FLUSH;
                    w_pc_we = 1'b0;
                end
            end
            ST_LSTALL: begin
                if (branch_taken) begin
                    w_if_pm = PM_FLUSH;
                    w_id_ex = PM_FLUSH;
                end else begin
                    w_if_pm = PM_FREEZE;
                    w_id_ex = PM_FLUSH;
                    w_pc_we = 1'b0;
                end
            end
            ST_FLUSH: begin
                w_if_pm = PM_FLUSH;
                w_id_ex = PM_FLUSH;
            end
            ST_MC_WAIT: begin
                if (!w_mc_release) begin
                    w_if_pm = PM_FREEZE;
                    w_id_ex = PM_FREEZE;
                    w_pc_we = 1'b0;
                end
            end
            default: begin
                w_if_pm = PM_NORMAL;
                w_id_ex = PM_NORMAL;
                w_pc_we = 1'b1;
            end
        endcase
    end

    // Reset forces idle controls regardless of state or inputs
    assign mux_if_pm   = reset_n ? w_if_pm : PM_NORMAL;
    assign mux_id_ex   = reset_n ? w_id_ex : PM_NORMAL;
    assign pc_write_en = reset_n ? w_pc_we : 1'b1;
    assign mc_timeout  = r_mc_timeout;

    assign w_stall_inc = ~pc_write_en;

    sat_counter #(
        .WIDTH (PERF_W)
    ) u_stall_cnt (
        .clk     (clk),
        .i_clr_n (reset_n),
        .i_inc   (w_stall_inc),
        .o_count (stall_cnt)
    );

    sat_counter #(
        .WIDTH (PERF_W)
    ) u_flush_cnt (
        .clk     (clk),
        .i_clr_n (reset_n),
        .i_inc   (w_flush_inc),
        .o_count (flush_cnt)
    );

endmodule
`default_nettype wire
